// File: rtl/rv32i_io_pkg.sv
// Shared definitions for the core-to-I/O bus bridge: FSM state encoding,
// byte-enable patterns and the I/O address width used by the responder.
package rv32i_io_pkg;

  localparam int IO_ADDR_WIDTH = 15;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD      = 3'd1,
    RD_WAIT = 3'd2,
    WR      = 3'd3,
    RESP    = 3'd4
  } io_br_state_t;

  localparam logic [3:0] BE_NONE    = 4'b0000;
  localparam logic [3:0] BE_WORD    = 4'b1111;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_BYTE0   = 4'b0001;
  localparam logic [3:0] BE_BYTE1   = 4'b0010;
  localparam logic [3:0] BE_BYTE2   = 4'b0100;
  localparam logic [3:0] BE_BYTE3   = 4'b1000;

  // True for the byte-enable shapes a store may legally carry (0000 excluded;
  // it is handled separately as a no-op store).
  function automatic logic be_legal(input logic [3:0] be);
    case (be)
      BE_WORD, BE_HALF_LO, BE_HALF_HI,
      BE_BYTE0, BE_BYTE1, BE_BYTE2, BE_BYTE3: be_legal = 1'b1;
      default:                                be_legal = 1'b0;
    endcase
  endfunction

  // Word access off a word boundary, or halfword access off a halfword boundary.
  function automatic logic be_misaligned(input logic [3:0] be, input logic [1:0] addr_lo);
    be_misaligned = ((be == BE_WORD) && (addr_lo != 2'b00)) ||
                    (((be == BE_HALF_LO) || (be == BE_HALF_HI)) && addr_lo[0]);
  endfunction

endpackage

// File: rtl/rv32i_be_merge.sv
// Byte-lane merge: lanes with be=1 come from new_word, the rest from old_word.
module rv32i_be_merge
  import rv32i_io_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] new_word,
  input  logic [3:0]  be,
  output logic [31:0] merged
);

  // Per-lane select between the existing word and the store data.
  always_comb begin
    merged = old_word;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) merged[8*i +: 8] = new_word[8*i +: 8];
    end
  end

endmodule

// File: rtl/rv32i_io_bridge.sv
// Core data-port to I/O bus bridge. Each load or store becomes a single-cycle
// I/O transfer; sub-word stores are done as read-modify-write because the I/O
// bus has no byte enables. The core is held off until d_ready pulses.
//
// Handshake: d_req is sampled only in IDLE and must be held until d_ready;
// d_ready is a one-cycle pulse from the RESP state, with d_err and d_rdata
// valid in that same cycle. io_we is a one-cycle strobe in WR; a read is
// issued in RD and the responder's registered io_rdata is sampled in RD_WAIT.
module rv32i_io_bridge
  import rv32i_io_pkg::*;
#(
  parameter int ADDR_WIDTH = IO_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [31:0]           d_addr,
  input  logic [3:0]            d_be,
  input  logic [31:0]           d_wdata,
  output logic [31:0]           d_rdata,
  output logic                  d_ready,
  output logic                  d_err,
  output logic                  io_we,
  output logic [ADDR_WIDTH-1:0] io_addr,
  output logic [31:0]           io_wdata,
  input  logic [31:0]           io_rdata,
  output logic [2:0]            state_dbg
);

  io_br_state_t state, state_next;

  logic        we_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;
  logic        err_q;
  logic [31:0] wbuf;
  logic [31:0] rdata_q;
  logic [31:0] merged;
  logic        req_err;
  logic        unused_addr_hi;

  // Address bits above the I/O window are already decoded away by memTop.
  assign unused_addr_hi = ^d_addr[31:ADDR_WIDTH];

  // Request-time error: misalignment applies to every access, shape legality
  // only to stores with at least one lane enabled (loads ignore be).
  assign req_err = be_misaligned(d_be, d_addr[1:0]) |
                   (d_we & (d_be != BE_NONE) & ~be_legal(d_be));

  rv32i_be_merge u_merge (
    .old_word (io_rdata),
    .new_word (wdata_q),
    .be       (be_q),
    .merged   (merged)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state decode.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (d_req) begin
          if (req_err)                  state_next = RESP;
          else if (!d_we)               state_next = RD;
          else if (d_be == BE_NONE)     state_next = RESP;
          else if (d_be == BE_WORD)     state_next = WR;
          else                          state_next = RD;
        end
      end
      RD:      state_next = RD_WAIT;
      RD_WAIT: state_next = we_q ? WR : RESP;
      WR:      state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request latch, write buffer and load data capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      we_q    <= 1'b0;
      be_q    <= 4'b0000;
      wdata_q <= 32'h0;
      err_q   <= 1'b0;
      io_addr <= '0;
      wbuf    <= 32'h0;
      rdata_q <= 32'h0;
    end else begin
      if ((state == IDLE) && d_req) begin
        we_q    <= d_we;
        be_q    <= d_be;
        wdata_q <= d_wdata;
        err_q   <= req_err;
        io_addr <= {d_addr[ADDR_WIDTH-1:2], 2'b00};
        if (d_we && (d_be == BE_WORD) && !req_err) wbuf <= d_wdata;
      end
      if (state == RD_WAIT) begin
        if (we_q) wbuf    <= merged;
        else      rdata_q <= io_rdata;
      end
    end
  end

  assign io_we     = (state == WR);
  assign io_wdata  = wbuf;
  assign d_ready   = (state == RESP);
  assign d_err     = (state == RESP) & err_q;
  assign d_rdata   = rdata_q;
  assign state_dbg = state;

endmodule

// File: tb/tb_rv32i_io_bridge.sv
// Bench for rv32i_io_bridge: a memory-backed I/O responder, a driver that
// issues core accesses and predicts each response from a word-array model,
// and a monitor that checks every d_ready and io_we against the predictions.
module tb_rv32i_io_bridge;

  localparam int AW = 15;
  localparam int EW = 65;  // {cycle[31:0], err, rdata[31:0]}
  localparam int WW = 79;  // {cycle[31:0], addr[14:0], data[31:0]}

  logic          clk;
  logic          reset;
  logic          d_req;
  logic          d_we;
  logic [31:0]   d_addr;
  logic [3:0]    d_be;
  logic [31:0]   d_wdata;
  logic [31:0]   d_rdata;
  logic          d_ready;
  logic          d_err;
  logic          io_we;
  logic [AW-1:0] io_addr;
  logic [31:0]   io_wdata;
  logic [31:0]   io_rdata;
  logic [2:0]    state_dbg;

  rv32i_io_bridge #(.ADDR_WIDTH(AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_be      (d_be),
    .d_wdata   (d_wdata),
    .d_rdata   (d_rdata),
    .d_ready   (d_ready),
    .d_err     (d_err),
    .io_we     (io_we),
    .io_addr   (io_addr),
    .io_wdata  (io_wdata),
    .io_rdata  (io_rdata),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset / cycle counter ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- I/O responder ----------------
  bit [31:0] resp_mem [0:8191];
  bit        resp_written [0:8191];

  function automatic logic [31:0] init_word(input int idx);
    if (idx == 0) return 32'h0000_0001;  // KEY input pressed
    return idx * 32'h9E37_79B1 + 32'h0123_4567;
  endfunction

  always @(posedge clk) begin
    if (io_we) begin
      resp_mem[io_addr[AW-1:2]]     <= io_wdata;
      resp_written[io_addr[AW-1:2]] <= 1'b1;
    end
    io_rdata <= resp_written[io_addr[AW-1:2]] ? resp_mem[io_addr[AW-1:2]]
                                              : init_word(int'(io_addr[AW-1:2]));
  end

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [EW-1:0] exp_q[$];
  logic [WW-1:0] wr_q[$];
  logic [31:0]   ref_mem [0:8191];
  logic [31:0]   exp_rdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // A legal enable pattern is a contiguous run of 1, 2 or 4 lanes starting on
  // a lane that is a multiple of its length; the access must then sit on a
  // byte address that is a multiple of its length.
  function automatic bit model_err(input bit we, input logic [3:0] be, input logic [31:0] addr);
    int n, low;
    bit shape_ok, misal;
    n = 0;
    low = 0;
    for (int i = 3; i >= 0; i--) if (be[i]) begin n++; low = i; end
    shape_ok = (n == 1 || n == 2 || n == 4) &&
               (be == 4'(((1 << n) - 1) << low)) && (low % n == 0);
    misal = shape_ok && ((int'(addr[1:0]) % n) != 0);
    if (we) return ((be != 4'b0000) && !shape_ok) || misal;
    return misal;
  endfunction

  // ---------------- driver ----------------
  task automatic access(input bit we, input logic [31:0] addr, input logic [3:0] be,
                        input logic [31:0] wdata);
    int t0, lat, word;
    bit err;
    bit got;
    logic [31:0] m;
    @(negedge clk);
    d_req   = 1'b1;
    d_we    = we;
    d_addr  = addr;
    d_be    = be;
    d_wdata = wdata;
    t0 = cyc;
    err = model_err(we, be, addr);
    word = int'(addr[AW-1:2]);
    if (err || (we && be == 4'b0000)) begin
      lat = 1;
    end else if (!we) begin
      lat = 3;
      exp_rdata = ref_mem[word];
    end else begin
      m = ref_mem[word];
      for (int i = 0; i < 4; i++) if (be[i]) m[8*i +: 8] = wdata[8*i +: 8];
      ref_mem[word] = m;
      lat = (be == 4'b1111) ? 2 : 4;
      wr_q.push_back({32'(t0 + lat - 1), {addr[AW-1:2], 2'b00}, m});
    end
    exp_q.push_back({32'(t0 + lat), err, exp_rdata});
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      @(posedge clk);
      #1;
      if (d_ready) got = 1'b1;
    end
    if (!got) chk("d_ready_timeout", 0, 1);
    @(negedge clk);
    d_req   = 1'b0;
    d_we    = 1'($urandom);
    d_addr  = $urandom;
    d_be    = 4'($urandom);
    d_wdata = $urandom;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_io_we"},    32'(io_we), 0);
    chk({tag, "_io_addr"},  32'(io_addr), 0);
    chk({tag, "_io_wdata"}, io_wdata, 0);
    chk({tag, "_d_rdata"},  d_rdata, 0);
    chk({tag, "_d_ready"},  32'(d_ready), 0);
    chk({tag, "_d_err"},    32'(d_err), 0);
    chk({tag, "_state"},    32'(state_dbg), 0);
  endtask

  // ---------------- monitor ----------------
  logic [EW-1:0] mon_e;
  logic [WW-1:0] mon_w;

  always @(posedge clk) begin
    #1;
    if (io_we === 1'b1) begin
      if (wr_q.size() == 0) begin
        chk("unexpected_io_we", 32'(io_addr), 32'hFFFF_FFFF);
      end else begin
        mon_w = wr_q.pop_front();
        chk("io_we_cycle", cyc, mon_w[78:47]);
        chk("io_addr",     32'(io_addr), 32'(mon_w[46:32]));
        chk("io_wdata",    io_wdata, mon_w[31:0]);
      end
    end
    if (d_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_d_ready", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("d_ready_cycle", cyc, mon_e[64:33]);
        chk("d_err",         32'(d_err), 32'(mon_e[32]));
        chk("d_rdata",       d_rdata, mon_e[31:0]);
      end
    end else if (d_err !== 1'b0) begin
      chk("d_err_without_ready", 32'(d_err), 0);
    end
  end

  // ---------------- stimulus ----------------
  logic [3:0] legal_be [7] = '{4'hF, 4'h3, 4'hC, 4'h1, 4'h2, 4'h4, 4'h8};

  initial begin
    bit we;
    logic [3:0] be;
    logic [31:0] addr;
    int wait_n;

    for (int i = 0; i < 8192; i++) ref_mem[i] = init_word(i);
    exp_rdata = 32'h0;
    reset   = 1'b1;
    d_req   = 1'b0;
    d_we    = 1'b0;
    d_addr  = 32'h0;
    d_be    = 4'h0;
    d_wdata = 32'h0;

    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    reset = 1'b0;
    idle(1);

    // Directed cases.
    access(1'b1, 32'h0000_0010, 4'b1111, 32'h0000_02A5);  // full store
    access(1'b0, 32'h0000_0000, 4'b1111, 32'h0);          // load KEY=1
    access(1'b1, 32'h0000_0010, 4'b1111, 32'h0000_03FF);  // prior word
    access(1'b1, 32'h0000_0011, 4'b0010, 32'h0000_5A00);  // byte RMW -> 0x5AFF
    access(1'b1, 32'h0000_0012, 4'b1111, 32'hDEAD_BEEF);  // misaligned word
    access(1'b1, 32'h0000_0014, 4'b0110, 32'hDEAD_BEEF);  // illegal be
    access(1'b1, 32'h0000_0014, 4'b0000, 32'hDEAD_BEEF);  // no-op store
    access(1'b1, 32'h0000_0020, 4'b1111, 32'h1234_5678);  // back-to-back store
    access(1'b0, 32'h0000_0010, 4'b1111, 32'h0);          // ...then load
    access(1'b0, 32'h0000_0021, 4'b0011, 32'h0);          // misaligned half load
    access(1'b1, 32'h0000_0022, 4'b1100, 32'hABCD_0000);  // upper half RMW
    access(1'b0, 32'h0000_0020, 4'b0001, 32'h0);

    // Randomized traffic over a small window so words get reused.
    for (int n = 0; n < 250; n++) begin
      we   = 1'($urandom_range(0, 1));
      addr = {$urandom_range(0, 15), 2'b00} | 32'($urandom_range(0, 3));
      be   = legal_be[$urandom_range(0, 6)];
      if (we && $urandom_range(0, 7) == 0) be = 4'($urandom_range(0, 15));
      idle($urandom_range(0, 2));
      access(we, addr, be, $urandom);
    end

    // Reset during RD_WAIT of a partial store: no write may reach the bus.
    @(negedge clk);
    d_req   = 1'b1;
    d_we    = 1'b1;
    d_addr  = 32'h0000_0015;
    d_be    = 4'b0100;
    d_wdata = 32'h00EE_0000;
    @(negedge clk);            // RD
    d_req = 1'b0;
    @(negedge clk);            // RD_WAIT
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_reset_outputs("rst_rmw");
    @(negedge clk);
    reset = 1'b0;
    exp_rdata = 32'h0;
    idle(2);
    access(1'b0, 32'h0000_0014, 4'b1111, 32'h0);  // word 5 unchanged
    access(1'b0, 32'h0000_0010, 4'b1111, 32'h0);

    wait_n = 0;
    while ((exp_q.size() != 0 || wr_q.size() != 0) && wait_n < 20) begin
      @(negedge clk);
      wait_n++;
    end
    idle(3);
    chk("exp_q_drained", 32'(exp_q.size()), 0);
    chk("wr_q_drained",  32'(wr_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Overall time bound.
  initial begin
    #500000;
    chk("watchdog", 1, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rv32i_io_bridge.md
# rv32i_io_bridge

Bus initiator between the core's data-memory port (as decoded by memTop) and the memory-mapped I/O responder (keys in, LEDs out). Turns each core load or store into single-cycle transfers on the I/O bus (io_we / io_addr / io_wdata out, io_rdata in). The I/O bus has no byte enables, so sub-word stores are done as read-modify-write. The core is stalled through d_ready until each access completes.

## Interface
- ADDR_WIDTH, 15: I/O bus address width; must match the responder.
- clk  in  1: system clock, all logic on rising edge.
- reset  in  1: synchronous, active-high.
- d_req  in  1: core access request. Already I/O-region qualified by memTop. Held until d_ready.
- d_we  in  1: 1 = store, 0 = load.
- d_addr  in  32: byte address.
- d_be  in  4: byte enables (lane n = bits 8n+7:8n).
- d_wdata  in  32: store data, already lane-aligned.
- d_rdata  out  32: load data, full word. The core does alignment and extension.
- d_ready  out  1: one-cycle completion pulse.
- d_err  out  1: alignment/byte-enable error, valid with d_ready.
- io_we  out  1: I/O write strobe.
- io_addr  out  ADDR_WIDTH: word address; bits 1:0 always 0.
- io_wdata  out  32: I/O write data.
- io_rdata  in  32: I/O read data, registered by the responder one cycle after io_addr with io_we=0.

## Operation
- States: IDLE, RD, RD_WAIT, WR, RESP.
- IDLE:
  - d_req=1 latches d_we, d_be, d_wdata, and io_addr = {d_addr[ADDR_WIDTH-1:2], 2'b00}.
  - Misaligned access or illegal d_be goes to RESP with err=1 and no I/O transaction.
    - Misaligned: be=1111 with addr[1:0]≠0, or be=0011/1100 with addr[0]=1.
    - Legal d_be: 1111, 0011, 1100, 0001, 0010, 0100, 1000. A store with be=0000 completes as a no-op (RESP, no io_we). A load ignores be.
  - Load: → RD.
  - Store, be=1111: → WR, with the write buffer loaded from d_wdata.
  - Store, partial be: → RD (read-modify-write).
- RD: io_we=0 and io_addr driven; the responder captures its read this cycle. → RD_WAIT.
- RD_WAIT: sample io_rdata at the edge.
  - Load: into d_rdata, → RESP.
  - Partial store: merge, taking d_wdata lanes where be=1 and io_rdata lanes elsewhere, into the write buffer, → WR.
- WR: io_we=1 for exactly one cycle, io_wdata = write buffer. → RESP.
- RESP: d_ready=1, d_err=err flag, d_rdata stable. → IDLE.
- d_req is ignored outside IDLE. A request presented in the cycle after RESP is accepted, so there is one idle cycle between back-to-back accesses.
- io_addr holds its last value between transactions. io_we is 0 in every state except WR.

## Timing
- Reset values: io_we=0, io_addr=0, io_wdata=0, d_rdata=0, d_ready=0, d_err=0, state IDLE.
- Latency is measured from the request cycle (cycle 0, IDLE) to the d_ready cycle:
  - Error or no-op: 1.
  - Full-word store: 2, with io_we in cycle 1.
  - Load: 3.
  - Partial store: 4, with io_we in cycle 3.
- d_rdata updates only on load completion. It holds otherwise, including through stores.
- Reset asserted in any state: IDLE at the next edge and all outputs return to reset values.
  - A read-modify-write aborted before WR performs no write.
  - Reset sampled in the WR cycle still lets that cycle's io_we be seen by the responder, because both sample the same edge.
- d_ready and d_err are registered outputs (state-decoded from registered state). There is no combinational path from d_req to any output.

## Structure
- Package rv32i_io_pkg:
  - state enum io_br_state_t (IDLE, RD, RD_WAIT, WR, RESP).
  - localparams for the legal byte-enable patterns.
  - default IO_ADDR_WIDTH=15, shared with the responder.
- Sub-module rv32i_be_merge: combinational (old, new, be) → merged word. Reused by the data-memory RMW path.
- The top holds the FSM, the latched request registers and the write buffer.

## Test plan
- Full store: addr=0x0000_0010, be=1111, wdata=0x0000_02A5 → io_we high exactly in cycle 1 with io_addr=0x10 and io_wdata=0x2A5; d_ready in cycle 2; d_err=0.
- Load: responder returns KEY=1, i.e. io_rdata=0x0000_0001 → d_rdata=0x1 with d_ready in cycle 3; io_we stays 0 throughout.
- Byte store RMW: prior word 0x0000_03FF, addr=0x11, be=0010, wdata=0x0000_5A00 → single io_we in cycle 3 with io_wdata=0x0000_5AFF; d_ready in cycle 4.
- Errors:
  - addr=0x12 with be=1111 → d_ready and d_err in cycle 1, no io_we.
  - be=0110 → same response.
- Back-to-back: a store then a load, with d_req re-asserted in the cycle after d_ready → both complete in order, latencies 2 and 3 plus one IDLE cycle between them.
- Reset in RD_WAIT of a partial store → no io_we ever, all outputs 0 on the next cycle; a fresh load afterwards completes normally.
